// File: rtl/video_timing_generator.sv
// Line/frame timing for a composite video encoder: free-running h/v counters
// per standard, with registered sync, burst, SECAM, active and position outputs.
package video_timing_pkg;
  typedef enum logic [1:0] {
    VS_PAL   = 2'd0,
    VS_NTSC  = 2'd1,
    VS_SECAM = 2'd2
  } video_standard_e;
endpackage

module video_timing_generator
  import video_timing_pkg::*;
#(
  parameter int PAL_LINE_CLKS          = 3072,
  parameter int NTSC_LINE_CLKS         = 3048,
  parameter int PAL_LINES              = 312,
  parameter int NTSC_LINES             = 262,
  parameter int HSYNC_CLKS             = 226,
  parameter int BURST_START_CLKS       = 269,
  parameter int ACTIVE_START_CLKS      = 504,
  parameter int ACTIVE_LEN_CLKS        = 2496,
  parameter int VSYNC_LINES            = 3,
  parameter int PAL_FIRST_ACTIVE_LINE  = 23,
  parameter int NTSC_FIRST_ACTIVE_LINE = 20
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable,
  input  video_standard_e video_standard,
  output video_standard_e active_standard,
  output logic            sync,
  output logic            newframe,
  output logic            newline,
  output logic            qam_startburst,
  output logic            secam_enabled,
  output logic            active,
  output logic [8:0]      line,
  output logic [11:0]     hpos
);

  if (!((HSYNC_CLKS < BURST_START_CLKS) && (BURST_START_CLKS < ACTIVE_START_CLKS) &&
        (ACTIVE_START_CLKS + ACTIVE_LEN_CLKS <= NTSC_LINE_CLKS))) begin : g_param_check
    $error("video_timing_generator: illegal timing parameters");
  end

  localparam logic [11:0] PAL_LEN    = 12'(PAL_LINE_CLKS);
  localparam logic [11:0] NTSC_LEN   = 12'(NTSC_LINE_CLKS);
  localparam logic [11:0] HSYNC      = 12'(HSYNC_CLKS);
  localparam logic [11:0] BURST      = 12'(BURST_START_CLKS);
  localparam logic [11:0] ACT_START  = 12'(ACTIVE_START_CLKS);
  localparam logic [11:0] ACT_END    = 12'(ACTIVE_START_CLKS + ACTIVE_LEN_CLKS);
  localparam logic [8:0]  PAL_NL     = 9'(PAL_LINES);
  localparam logic [8:0]  NTSC_NL    = 9'(NTSC_LINES);
  localparam logic [8:0]  VSYNC_L    = 9'(VSYNC_LINES);
  localparam logic [8:0]  PAL_FIRST  = 9'(PAL_FIRST_ACTIVE_LINE);
  localparam logic [8:0]  NTSC_FIRST = 9'(NTSC_FIRST_ACTIVE_LINE);

  logic            running_q, running_d;
  logic [11:0]     h_q, h_d;
  logic [8:0]      v_q, v_d;
  video_standard_e std_q, std_d;

  video_standard_e active_standard_q, active_standard_d;
  logic            sync_q, sync_d;
  logic            newframe_q, newframe_d;
  logic            newline_q, newline_d;
  logic            qam_q, qam_d;
  logic            secam_q, secam_d;
  logic            active_q, active_d;
  logic [8:0]      line_q, line_d;
  logic [11:0]     hpos_q, hpos_d;

  logic [11:0]     line_len;
  logic [8:0]      n_lines;
  logic [8:0]      first_line;
  logic            h_last, v_last, vsync_line;

  always_comb begin
    line_len   = (std_q == VS_NTSC) ? NTSC_LEN : PAL_LEN;
    n_lines    = (std_q == VS_NTSC) ? NTSC_NL : PAL_NL;
    first_line = (std_q == VS_NTSC) ? NTSC_FIRST : PAL_FIRST;
    h_last     = (h_q == line_len - 12'd1);
    v_last     = (v_q == n_lines - 9'd1);
    vsync_line = (v_q < VSYNC_L);

    running_d         = 1'b0;
    h_d               = '0;
    v_d               = '0;
    std_d             = VS_PAL;
    active_standard_d = VS_PAL;
    sync_d            = 1'b0;
    newframe_d        = 1'b0;
    newline_d         = 1'b0;
    qam_d             = 1'b0;
    secam_d           = 1'b0;
    active_d          = 1'b0;
    line_d            = '0;
    hpos_d            = '0;

    if (enable) begin
      running_d = 1'b1;
      if (!running_q) begin
        // First enabled edge only arms the counters; outputs follow next cycle.
        std_d = video_standard;
      end else begin
        std_d = std_q;
        h_d   = h_last ? 12'd0 : h_q + 12'd1;
        v_d   = h_last ? (v_last ? 9'd0 : v_q + 9'd1) : v_q;
        if (h_last && v_last) std_d = video_standard;

        active_standard_d = std_q;
        sync_d     = vsync_line ? (h_q < line_len - HSYNC) : (h_q < HSYNC);
        newline_d  = (h_q == 12'd0);
        newframe_d = (h_q == 12'd0) && (v_q == 9'd0);
        qam_d      = (h_q == BURST) && !vsync_line && (std_q != VS_SECAM);
        secam_d    = (std_q == VS_SECAM) && !vsync_line && (h_q >= BURST) && (h_q < ACT_END);
        active_d   = (v_q >= first_line) && (v_q < n_lines) &&
                     (h_q >= ACT_START) && (h_q < ACT_END);
        line_d     = v_q;
        hpos_d     = h_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running_q         <= 1'b0;
      h_q               <= '0;
      v_q               <= '0;
      std_q             <= VS_PAL;
      active_standard_q <= VS_PAL;
      sync_q            <= 1'b0;
      newframe_q        <= 1'b0;
      newline_q         <= 1'b0;
      qam_q             <= 1'b0;
      secam_q           <= 1'b0;
      active_q          <= 1'b0;
      line_q            <= '0;
      hpos_q            <= '0;
    end else begin
      running_q         <= running_d;
      h_q               <= h_d;
      v_q               <= v_d;
      std_q             <= std_d;
      active_standard_q <= active_standard_d;
      sync_q            <= sync_d;
      newframe_q        <= newframe_d;
      newline_q         <= newline_d;
      qam_q             <= qam_d;
      secam_q           <= secam_d;
      active_q          <= active_d;
      line_q            <= line_d;
      hpos_q            <= hpos_d;
    end
  end

  assign active_standard = active_standard_q;
  assign sync            = sync_q;
  assign newframe        = newframe_q;
  assign newline         = newline_q;
  assign qam_startburst  = qam_q;
  assign secam_enabled   = secam_q;
  assign active          = active_q;
  assign line            = line_q;
  assign hpos            = hpos_q;

endmodule

// File: tb/tb_video_timing_generator.sv
// Bench for video_timing_generator with shrunk timing parameters so whole
// frames fit in a short run; a cycle scoreboard plus directed line scans.
module tb_video_timing_generator;
  import video_timing_pkg::*;

  localparam int PAL_LC  = 64;
  localparam int NTSC_LC = 60;
  localparam int PAL_NL  = 12;
  localparam int NTSC_NL = 10;
  localparam int HSYNC   = 6;
  localparam int BURST   = 9;
  localparam int ACT_S   = 14;
  localparam int ACT_L   = 40;
  localparam int VSYNC_L = 3;
  localparam int PAL_FA  = 5;
  localparam int NTSC_FA = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            enable = 1'b0;
  video_standard_e video_standard = VS_PAL;
  video_standard_e active_standard;
  logic            sync, newframe, newline, qam_startburst, secam_enabled, active;
  logic [8:0]      line;
  logic [11:0]     hpos;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  logic [28:0] exp_q[$];

  video_timing_generator #(
    .PAL_LINE_CLKS(PAL_LC), .NTSC_LINE_CLKS(NTSC_LC), .PAL_LINES(PAL_NL),
    .NTSC_LINES(NTSC_NL), .HSYNC_CLKS(HSYNC), .BURST_START_CLKS(BURST),
    .ACTIVE_START_CLKS(ACT_S), .ACTIVE_LEN_CLKS(ACT_L), .VSYNC_LINES(VSYNC_L),
    .PAL_FIRST_ACTIVE_LINE(PAL_FA), .NTSC_FIRST_ACTIVE_LINE(NTSC_FA)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .video_standard(video_standard),
    .active_standard(active_standard), .sync(sync), .newframe(newframe),
    .newline(newline), .qam_startburst(qam_startburst), .secam_enabled(secam_enabled),
    .active(active), .line(line), .hpos(hpos)
  );

  always #5 clk = ~clk;

  function automatic logic [28:0] obs_vec();
    return {active_standard, sync, newframe, newline, qam_startburst, secam_enabled,
            active, line, hpos};
  endfunction

  function automatic logic [28:0] model_out(bit run, bit en, int v, int h, video_standard_e s);
    int len, nl, first;
    bit sy, nf, nln, q, se, ac;
    if (!(run && en)) return '0;
    len   = (s == VS_NTSC) ? NTSC_LC : PAL_LC;
    nl    = (s == VS_NTSC) ? NTSC_NL : PAL_NL;
    first = (s == VS_NTSC) ? NTSC_FA : PAL_FA;
    sy  = (v < VSYNC_L) ? (h < len - HSYNC) : (h < HSYNC);
    nln = (h == 0);
    nf  = nln && (v == 0);
    q   = (h == BURST) && (v >= VSYNC_L) && (s != VS_SECAM);
    se  = (s == VS_SECAM) && (v >= VSYNC_L) && (h >= BURST) && (h < ACT_S + ACT_L);
    ac  = (v >= first) && (v < nl) && (h >= ACT_S) && (h < ACT_S + ACT_L);
    return {s, sy, nf, nln, q, se, ac, 9'(v), 12'(h)};
  endfunction

  // Reference model: expected output for the cycle after each edge.
  initial begin : model
    bit m_run;
    int m_v, m_h, len, nl;
    video_standard_e m_std;
    m_run = 0; m_v = 0; m_h = 0; m_std = VS_PAL;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_run = 0; m_v = 0; m_h = 0; m_std = VS_PAL;
        exp_q.delete();
      end else begin
        exp_q.push_back(model_out(m_run, enable, m_v, m_h, m_std));
        len = (m_std == VS_NTSC) ? NTSC_LC : PAL_LC;
        nl  = (m_std == VS_NTSC) ? NTSC_NL : PAL_NL;
        if (!enable) begin
          m_run = 0; m_v = 0; m_h = 0; m_std = VS_PAL;
        end else if (!m_run) begin
          m_run = 1; m_v = 0; m_h = 0; m_std = video_standard;
        end else if (m_h == len - 1) begin
          m_h = 0;
          if (m_v == nl - 1) begin
            m_v = 0; m_std = video_standard;
          end else m_v++;
        end else m_h++;
      end
    end
  end

  initial begin : scoreboard
    logic [28:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        assert (obs_vec() === e) else begin
          n_err++;
          $error("FAIL scoreboard cyc=%0d observed=%h expected=%h", cyc, obs_vec(), e);
        end
      end
    end
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string tag, input int observed, input int expected);
    n_vec++;
    assert (observed === expected) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_line(input int target);
    int k = 0;
    while (!(newline && line == 9'(target)) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk($sformatf("reach_line_%0d", target), int'(k < 3000), 1);
  endtask

  // Samples one whole line starting at its newline cycle; ends on the next newline.
  task automatic scan_line(output int len, output int n_sync, output int sync_last,
                           output int qam_n, output int qam_pos, output int act_first,
                           output int act_last, output int sec_n, output int sec_first);
    len = 0; n_sync = 0; sync_last = -1; qam_n = 0; qam_pos = -1;
    act_first = -1; act_last = -1; sec_n = 0; sec_first = -1;
    do begin
      if (sync) begin n_sync++; sync_last = int'(hpos); end
      if (qam_startburst) begin qam_n++; qam_pos = int'(hpos); end
      if (active) begin
        if (act_first < 0) act_first = int'(hpos);
        act_last = int'(hpos);
      end
      if (secam_enabled) begin
        if (sec_first < 0) sec_first = int'(hpos);
        sec_n++;
      end
      len++;
      @(negedge clk);
    end while (!newline && len < 5000);
  endtask

  initial begin : stimulus
    int len, ns, sl, qn, qp, af, al, sn, sf, k, t0, t1;

    // Reset and idle
    step(3);
    chk("reset_idle", int'(obs_vec()), 0);
    rst_n = 1'b1;
    step(3);
    chk("idle_disabled", int'(obs_vec()), 0);

    // PAL start
    enable = 1'b1;
    k = 0;
    while (!newframe && k < 8) begin @(negedge clk); k++; end
    chk("start_newframe", int'(newframe), 1);
    chk("start_newline", int'(newline), 1);
    chk("start_pos", int'({line, hpos}), 0);
    t0 = cyc;
    scan_line(len, ns, sl, qn, qp, af, al, sn, sf);
    chk("pal_line_period", len, PAL_LC);
    scan_line(len, ns, sl, qn, qp, af, al, sn, sf);
    chk("pal_broad_sync_n", ns, PAL_LC - HSYNC);
    chk("pal_broad_sync_last", sl, PAL_LC - HSYNC - 1);
    chk("pal_broad_qam", qn, 0);
    chk("pal_broad_active", af, -1);
    wait_line(5);
    scan_line(len, ns, sl, qn, qp, af, al, sn, sf);
    chk("pal_l5_sync_n", ns, HSYNC);
    chk("pal_l5_sync_last", sl, HSYNC - 1);
    chk("pal_l5_qam_n", qn, 1);
    chk("pal_l5_qam_pos", qp, BURST);
    chk("pal_l5_act_first", af, ACT_S);
    chk("pal_l5_act_last", al, ACT_S + ACT_L - 1);
    chk("pal_l5_secam", sn, 0);
    wait_line(0);
    t1 = cyc;
    chk("pal_frame_period", t1 - t0, PAL_LC * PAL_NL);

    // Mid-frame switch to NTSC takes effect only at the next frame
    wait_line(7);
    video_standard = VS_NTSC;
    wait_line(11);
    scan_line(len, ns, sl, qn, qp, af, al, sn, sf);
    chk("pal_last_line_period", len, PAL_LC);
    chk("switch_newframe", int'(newframe), 1);
    chk("switch_std", int'(active_standard), int'(VS_NTSC));
    t0 = cyc;
    scan_line(len, ns, sl, qn, qp, af, al, sn, sf);
    chk("ntsc_line_period", len, NTSC_LC);
    wait_line(NTSC_FA - 1);
    scan_line(len, ns, sl, qn, qp, af, al, sn, sf);
    chk("ntsc_pre_active", af, -1);
    chk("ntsc_first_line_num", int'(line), NTSC_FA);
    scan_line(len, ns, sl, qn, qp, af, al, sn, sf);
    chk("ntsc_first_active_h", af, ACT_S);
    wait_line(0);
    t1 = cyc;
    chk("ntsc_frame_period", t1 - t0, NTSC_LC * NTSC_NL);

    // SECAM
    video_standard = VS_SECAM;
    wait_line(5);
    wait_line(0);
    chk("secam_std", int'(active_standard), int'(VS_SECAM));
    wait_line(6);
    scan_line(len, ns, sl, qn, qp, af, al, sn, sf);
    chk("secam_qam_n", qn, 0);
    chk("secam_en_n", sn, ACT_S + ACT_L - BURST);
    chk("secam_en_first", sf, BURST);
    chk("secam_line_period", len, PAL_LC);

    // Drop enable mid-line, then restart
    wait_line(5);
    step($urandom_range(5, 40));
    enable = 1'b0;
    @(negedge clk);
    chk("idle_after_drop", int'(obs_vec()), 0);
    step(5);
    chk("idle_hold", int'(obs_vec()), 0);
    video_standard = VS_PAL;
    enable = 1'b1;
    k = 0;
    while (!newframe && k < 8) begin @(negedge clk); k++; end
    chk("restart_newframe", int'(newframe), 1);
    chk("restart_pos", int'({line, hpos}), 0);
    chk("restart_std", int'(active_standard), int'(VS_PAL));

    // Asynchronous reset mid-line from a SECAM frame
    video_standard = VS_SECAM;
    wait_line(0);
    wait_line(4);
    step($urandom_range(3, 30));
    #3 rst_n = 1'b0;
    #1 chk("async_reset_idle", int'(obs_vec()), 0);
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    while (!newframe && k < 8) begin @(negedge clk); k++; end
    chk("post_reset_newframe", int'(newframe), 1);
    chk("post_reset_std", int'(active_standard), int'(VS_SECAM));
    step(PAL_LC * 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
